bram_dp_arbiter: RTL

BRAM_DP_ARBITER -- requirements
Module: bram_dp_arbiter

---
 rtl/bram_dp_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bram_dp_arbiter.sv
// Two-requester round-robin arbiter in front of a simple dual-port BRAM (port A write, port B read).
// Optional read-after-write forwarding is enabled by defining BRAM_DP_ARBITER_FWD_EN.
module bram_dp_arbiter #(
   parameter int RAM_WIDTH     = 8,
   parameter int RAM_ADDR_BITS = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [1:0]                 wr_req_i,
   input  logic [2*RAM_ADDR_BITS-1:0] wr_addr_i,
   input  logic [2*RAM_WIDTH-1:0]     wr_data_i,
   output logic [1:0]                 wr_gnt_o,
   input  logic [1:0]                 rd_req_i,
   input  logic [2*RAM_ADDR_BITS-1:0] rd_addr_i,
   output logic [1:0]                 rd_gnt_o,
   output logic [1:0]                 rd_valid_o,
   output logic [RAM_WIDTH-1:0]       rd_data_o,
   output logic [RAM_ADDR_BITS-1:0]   mem_addr_a_o,
   output logic [RAM_WIDTH-1:0]       mem_data_a_o,
   output logic                       mem_we_a_o,
   output logic [RAM_ADDR_BITS-1:0]   mem_addr_b_o,
   output logic                       mem_en_b_o,
   input  logic [RAM_WIDTH-1:0]       mem_data_b_i
);

   typedef enum logic {
      PRIO_REQ0 = 1'b0,
      PRIO_REQ1 = 1'b1
   } prio_e;

   prio_e wr_prio_q, wr_prio_d;
   prio_e rd_prio_q, rd_prio_d;

   logic [1:0] wr_gnt;
   logic [1:0] rd_gnt;
   logic       rd_id_q;

   function automatic logic [1:0] arb2(input logic [1:0] req, input prio_e prio);
      logic [1:0] gnt;
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (prio == PRIO_REQ1) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

   // Priority moves to the other requester after every grant and holds otherwise.
   function automatic prio_e next_prio(input logic [1:0] gnt, input prio_e prio);
      prio_e nxt;
      nxt = prio;
      if (gnt[0])
         nxt = PRIO_REQ1;
      else if (gnt[1])
         nxt = PRIO_REQ0;
      return nxt;
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      wr_gnt = 2'b00;
      rd_gnt = 2'b00;
      if (!rst_i) begin
         wr_gnt = arb2(wr_req_i, wr_prio_q);
         rd_gnt = arb2(rd_req_i, rd_prio_q);
      end
      wr_prio_d = next_prio(wr_gnt, wr_prio_q);
      rd_prio_d = next_prio(rd_gnt, rd_prio_q);
   end

   assign wr_gnt_o = wr_gnt;
   assign rd_gnt_o = rd_gnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_prio_q <= PRIO_REQ0;
         rd_prio_q <= PRIO_REQ0;
      end else begin
         // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
         wr_prio_q <= wr_prio_d;
         rd_prio_q <= rd_prio_d;
      end
   end

   // Write port: capture the granted requester's address and data for one BRAM write cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: datapath registers are reset along with the control bits so outputs are never X after reset.
         mem_we_a_o   <= 1'b0;
         mem_addr_a_o <= '0;
         mem_data_a_o <= '0;
      end else begin
         mem_we_a_o <= |wr_gnt;
         if (wr_gnt[1]) begin
            mem_addr_a_o <= wr_addr_i[RAM_ADDR_BITS +: RAM_ADDR_BITS];
            mem_data_a_o <= wr_data_i[RAM_WIDTH +: RAM_WIDTH];
         end else if (wr_gnt[0]) begin
            mem_addr_a_o <= wr_addr_i[0 +: RAM_ADDR_BITS];
            mem_data_a_o <= wr_data_i[0 +: RAM_WIDTH];
         end
      end
   end

   // Read port: enable the BRAM, then steer the registered BRAM output to the requester id.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_en_b_o   <= 1'b0;
         mem_addr_b_o <= '0;
         rd_id_q      <= 1'b0;
         rd_valid_o   <= 2'b00;
      end else begin
         mem_en_b_o <= |rd_gnt;
         if (rd_gnt[1]) begin
            mem_addr_b_o <= rd_addr_i[RAM_ADDR_BITS +: RAM_ADDR_BITS];
            rd_id_q      <= 1'b1;
         end else if (rd_gnt[0]) begin
            mem_addr_b_o <= rd_addr_i[0 +: RAM_ADDR_BITS];
            rd_id_q      <= 1'b0;
         end
         rd_valid_o <= {mem_en_b_o & rd_id_q, mem_en_b_o & ~rd_id_q};
      end
   end

`ifdef BRAM_DP_ARBITER_FWD_EN
   logic                 fwd_hit_q;
   logic [RAM_WIDTH-1:0] fwd_data_q;

   // The BRAM is read-first; a same-address write in the read's enable cycle must win.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_hit_q  <= mem_we_a_o & mem_en_b_o & (mem_addr_a_o == mem_addr_b_o);
         fwd_data_q <= mem_data_a_o;
      end
   end

   assign rd_data_o = fwd_hit_q ? fwd_data_q : mem_data_b_i;
`else
   assign rd_data_o = mem_data_b_i;
`endif

endmodule
